mem_arbiter_rr: RTL
===================

Name: mem_arbiter_rr

Overview:
- Parametrised N-port line-request arbiter between L1 cache miss ports and one lower-level memory port (L2 cache or physical memory).
- Successor to the fixed two-port instruction/data arbiter, adding:
  - configurable port count, line width and address width;
  - selectable round-robin or fixed-priority mode;
  - registered lower-level requests;
  - per-port saturating grant counters for performance monitoring.

Parameters:
NUM_PORTS, 2, number of requesting ports (2..8)
LINE_W, 256, line data width in bits
ADDR_W, 32, address width in bits
RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (port 0 highest)
CNT_W, 16, width of each per-port grant counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_read  input  NUM_PORTS  per-port line read request, held until req_resp
req_write  input  NUM_PORTS  per-port line write request, held until req_resp
req_address  input  NUM_PORTS*ADDR_W  per-port address, port i at bits [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_PORTS*LINE_W  per-port write line, port i at bits [i*LINE_W +: LINE_W]
req_resp  output  NUM_PORTS  one-cycle completion pulse to the granted port
req_rdata  output  LINE_W  read line, broadcast to all ports, valid when req_resp bit is set
pmem_read  output  1  lower-level read request
pmem_write  output  1  lower-level write request
pmem_address  output  ADDR_W  lower-level address
pmem_wdata  output  LINE_W  lower-level write line
pmem_resp  input  1  lower-level completion
pmem_rdata  input  LINE_W  lower-level read line
grant_id  output  $clog2(NUM_PORTS)  index of current or last granted port
busy  output  1  transaction in flight
clear_counts  input  1  synchronous clear of all grant counters
grant_count  output  NUM_PORTS*CNT_W  per-port saturating grant counts

Behaviour:
- Reset: async on rst_n low.
  - FSM goes to IDLE.
  - pmem_read, pmem_write, busy and req_resp go to 0.
  - pmem_address, pmem_wdata and grant_id go to 0.
  - Round-robin pointer last_grant is set to NUM_PORTS-1, so port 0 wins first.
  - All grant counters go to 0.
- A port is requesting when req_read[i] or req_write[i] is set. If both are set, it is treated as a write; the read is ignored.
- IDLE state:
  - If no port is requesting, stay in IDLE.
  - Otherwise, at the edge, select winner w, latch req_address/req_wdata[w] and the op into pmem_* registers, set grant_id=w, and go to BUSY.
  - pmem_read or pmem_write is high from the next cycle; request-to-pmem latency is 1 cycle.
- Winner selection:
  - RR_MODE=1: first requesting port scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - RR_MODE=0: lowest-index requesting port.
- BUSY state:
  - pmem_* are held stable until pmem_resp. Requester inputs are not re-sampled; address and data changes mid-transaction are ignored.
  - In the cycle pmem_resp=1:
    - req_resp[grant_id]=1 combinationally; all other bits are 0.
    - req_rdata = pmem_rdata (passthrough; it is don't-care otherwise but driven with pmem_rdata).
  - At that edge: go to IDLE, clear pmem_read/pmem_write, update last_grant to grant_id, and increment grant_count[grant_id].
- Back-to-back transactions:
  - The cycle after completion is always IDLE; the requester has dropped its request by then.
  - The minimum gap between two lower-level transactions is 1 idle cycle.
  - Minimum L1-visible latency is 2 cycles plus the lower-level latency.
- A requester dropping its request during BUSY does not abort the transaction. It completes and the resp pulse is still issued.
- busy = 1 exactly in BUSY.
- grant_id holds the last winner while IDLE.
- Grant counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - clear_counts zeroes all counters at the edge and takes priority over a coincident increment.
- pmem_resp while IDLE is ignored: no req_resp is issued and there is no state change.
- Reset asserted mid-BUSY: the lower-level request is dropped immediately and no resp is issued. The lower level is required to tolerate the abandoned request.
- Fairness: in RR_MODE=1, with all ports continuously requesting, each port is granted once per NUM_PORTS transactions.

Test Plan:
1. Reset, NUM_PORTS=2, port1 reads address 0x0000_1040; pmem_resp 3 cycles after pmem_read rises, with pmem_rdata=0xAA..AA. Required: pmem_read high on the cycle after the request and pmem_address=0x0000_1040; req_resp=2'b10 for one cycle with req_rdata=0xAA..AA; grant_count[1]=1.
2. RR_MODE=1, NUM_PORTS=3, all ports continuously requesting reads. Required: grant order 0,1,2,0,1,2; each counter reads 2 after 6 transactions.
3. RR_MODE=0, ports 0 and 2 continuously requesting. Required: port 0 wins every transaction; port 2 never wins while port 0 requests.
4. Port 0 asserts read and write together with req_wdata=0x55..55 at address 0x200. Required: pmem_write=1, pmem_read=0, pmem_wdata=0x55..55, pmem_address=0x200.
5. CNT_W=2, port 0 completes 5 transactions; then clear_counts is asserted in the same cycle as a port 0 completion. Required: count is 3 after transaction 3 and still 3 after transaction 5; it then reads 0 after the clear edge.
6. rst_n pulsed low during BUSY, with pmem_resp asserted in the same cycle as the reset pulse. Required: pmem_read and busy drop to 0 immediately; no req_resp pulse; the next request goes to port 0.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// N-port line-request arbiter: L1 miss ports share one lower-level memory port.
// Round-robin or fixed-priority selection, registered pmem requests, per-port grant counters.
module mem_arbiter_rr #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RR_MODE   = 1,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned ID_W     = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [LINE_W-1:0]           req_rdata,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [ADDR_W-1:0]           pmem_address,
  output logic [LINE_W-1:0]           pmem_wdata,
  input  logic                        pmem_resp,
  input  logic [LINE_W-1:0]           pmem_rdata,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy,
  input  logic                        clear_counts,
  output logic [NUM_PORTS*CNT_W-1:0]  grant_count
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q, state_d;
  logic                  pmem_read_q, pmem_read_d;
  logic                  pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0]     pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0]     pmem_wdata_q, pmem_wdata_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]      cnt_d [NUM_PORTS];

  logic [NUM_PORTS-1:0]  requesting;
  logic [ID_W-1:0]       win;
  logic                  done_c;

  assign requesting = req_read | req_write;
  assign done_c     = (state_q == BUSY) && pmem_resp;

  // Winner: scan from last_grant+1 (round-robin) or from port 0 (fixed priority).
  always_comb begin
    int unsigned idx;
    logic        found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      if (RR_MODE != 0) begin
        idx = 32'(last_grant_q) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      end else begin
        idx = k - 1;
      end
      if (!found && requesting[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;

    case (state_q)
      IDLE: begin
        if (|requesting) begin
          state_d        = BUSY;
          grant_id_d     = win;
          pmem_write_d   = req_write[win];
          pmem_read_d    = !req_write[win];
          pmem_address_d = req_address[32'(win)*ADDR_W +: ADDR_W];
          pmem_wdata_d   = req_wdata[32'(win)*LINE_W +: LINE_W];
        end
      end
      BUSY: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          last_grant_d = grant_id_q;
          if (cnt_q[grant_id_q] != {CNT_W{1'b1}})
            cnt_d[grant_id_q] = cnt_q[grant_id_q] + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over a coincident increment.
    if (clear_counts) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) cnt_d[p] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      grant_id_q     <= '0;
      last_grant_q   <= ID_W'(NUM_PORTS - 1);
      for (int unsigned p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
    end else begin
      state_q        <= state_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
    end
  end

  assign req_resp     = done_c ? (NUM_PORTS'(1) << grant_id_q) : '0;
  assign req_rdata    = pmem_rdata;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign grant_id     = grant_id_q;
  assign busy         = (state_q == BUSY);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign grant_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule
